// File: rtl/qam_probe_capture.sv
`default_nettype none
// ============================================================================
//  Module      : qam_probe_capture
//  Description : Multi-channel capture buffer for QAM demod probe streams.
//                Records NUM_CH samples per strobe plus a post-valid tail and
//                streams them out sample-major on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_probe_capture #(
    parameter int NUM_CH      = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 1024,
    parameter int TAIL_CYCLES = 6,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                         axi_clk,
    input  logic                         axi_rstn,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [CNT_W-1:0]             sample_count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              ROW_W     = NUM_CH * DATA_WIDTH;
    localparam logic [2:0]      S_IDLE    = 3'd0;
    localparam logic [2:0]      S_ARMED   = 3'd1;
    localparam logic [2:0]      S_CAPTURE = 3'd2;
    localparam logic [2:0]      S_TAIL    = 3'd3;
    localparam logic [2:0]      S_READ    = 3'd4;
    localparam logic [6:0]      TAIL_LAST = 7'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0] CH_MAX    = CH_W'(NUM_CH - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [6:0]            tail_cnt_q, tail_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [ROW_W-1:0]      mem_q [DEPTH];
    logic [ROW_W-1:0]      rd_row_q;
    logic [CNT_W-1:0]      rd_smp_q;
    logic [CH_W-1:0]       rd_ch_q;
    logic                  rd_issued_q;
    logic                  s1_valid_q, s1_last_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic                  out_valid_q, out_last_q, done_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_ch_q;
    logic [DATA_WIDTH-1:0] w_row_ch [NUM_CH];

    logic w_full, w_arm_go, w_wr_en, w_adv, w_rd_issue, w_rd_last, w_last_hs;

    assign w_full     = (wr_ptr_q == CNT_W'(DEPTH));
    assign w_arm_go   = (state_q == S_IDLE) && arm && !abort;
    assign w_adv      = !out_valid_q || out_ready;
    assign w_rd_issue = (state_q == S_READ) && !rd_issued_q && w_adv && !abort;
    assign w_rd_last  = (rd_smp_q == (wr_ptr_q - CNT_W'(1))) && (rd_ch_q == CH_MAX);
    assign w_last_hs  = (state_q == S_READ) && out_valid_q && out_ready && out_last_q;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (arm) state_d = S_ARMED;
                S_ARMED:   if (in_valid) state_d = S_CAPTURE;
                S_CAPTURE: begin
                    if (w_full)                                 state_d = S_READ;
                    else if (!in_valid && TAIL_CYCLES <= 1)     state_d = S_READ;
                    else if (!in_valid)                         state_d = S_TAIL;
                end
                S_TAIL:    if (w_full || tail_cnt_q == TAIL_LAST) state_d = S_READ;
                S_READ:    if (w_last_hs) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        w_wr_en = 1'b0;
        if (!abort) begin
            case (state_q)
                S_ARMED:   w_wr_en = in_valid;
                S_CAPTURE: w_wr_en = !w_full && (in_valid || TAIL_CYCLES != 0);
                S_TAIL:    w_wr_en = !w_full;
                default:   w_wr_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        tail_cnt_d = tail_cnt_q;
        overflow_d = overflow_q;
        if (w_arm_go) begin
            wr_ptr_d   = '0;
            tail_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (state_q == S_CAPTURE && !in_valid) tail_cnt_d = 7'd1;
            else if (state_q == S_TAIL)            tail_cnt_d = tail_cnt_q + 7'd1;
        end else if (!abort && w_full && (state_q == S_CAPTURE || state_q == S_TAIL)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wr_ptr_q   <= '0;
            tail_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            tail_cnt_q <= tail_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Read is enabled only when the pipeline advances, so a stall freezes the row.
    always_ff @(posedge axi_clk) begin
        if (w_wr_en)    mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        if (w_rd_issue) rd_row_q <= mem_q[rd_smp_q[AW-1:0]];
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign w_row_ch[k] = rd_row_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rd_smp_q    <= '0;
            rd_ch_q     <= '0;
            rd_issued_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (w_arm_go) begin
            rd_smp_q    <= '0;
            rd_ch_q     <= '0;
            rd_issued_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (w_adv) begin
            s1_valid_q  <= w_rd_issue;
            s1_ch_q     <= rd_ch_q;
            s1_last_q   <= w_rd_last;
            out_valid_q <= s1_valid_q;
            out_data_q  <= w_row_ch[s1_ch_q];
            out_ch_q    <= s1_ch_q;
            out_last_q  <= s1_last_q;
            if (w_rd_issue) begin
                if (rd_ch_q == CH_MAX) begin
                    rd_ch_q  <= '0;
                    rd_smp_q <= rd_smp_q + CNT_W'(1);
                end else begin
                    rd_ch_q  <= rd_ch_q + CH_W'(1);
                end
                if (w_rd_last) rd_issued_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) done_q <= 1'b0;
        else           done_q <= w_last_hs && !abort;
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_ch       = out_ch_q;
    assign out_last     = out_last_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign sample_count = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_qam_probe_capture.sv
`default_nettype none
// Testbench for qam_probe_capture: two instances (tail 6 / tail 0) on shared
// stimulus, table of capture scenarios plus abort and reset sequences.
module tb_qam_probe_capture;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int DEP = 16;

    typedef struct {
        bit sel0;
        int nv;
        bit stall;
        int exp_cnt;
        bit exp_ovf;
        bit exp_early;
    } scn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, arm, abort, in_valid, out_ready, sel0;
    logic [NCH*DW-1:0] in_data;

    logic          ov6, last6, busy6, done6, ovf6, ov0, last0, busy0, done0, ovf0;
    logic [DW-1:0] data6, data0;
    logic [0:0]    ch6, ch0;
    logic [4:0]    cnt6, cnt0;

    logic          out_valid, out_last, busy, done, overflow;
    logic [DW-1:0] out_data;
    logic [0:0]    out_ch;
    logic [4:0]    sample_count;

    qam_probe_capture #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .TAIL_CYCLES(6)) u_dut6 (
        .axi_clk(clk), .axi_rstn(rstn), .arm(arm), .abort(abort),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov6), .out_ready(out_ready), .out_data(data6), .out_ch(ch6),
        .out_last(last6), .busy(busy6), .done(done6), .overflow(ovf6), .sample_count(cnt6)
    );

    qam_probe_capture #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .TAIL_CYCLES(0)) u_dut0 (
        .axi_clk(clk), .axi_rstn(rstn), .arm(arm), .abort(abort),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(data0), .out_ch(ch0),
        .out_last(last0), .busy(busy0), .done(done0), .overflow(ovf0), .sample_count(cnt0)
    );

    assign out_valid    = sel0 ? ov0   : ov6;
    assign out_last     = sel0 ? last0 : last6;
    assign busy         = sel0 ? busy0 : busy6;
    assign done         = sel0 ? done0 : done6;
    assign overflow     = sel0 ? ovf0  : ovf6;
    assign out_data     = sel0 ? data0 : data6;
    assign out_ch       = sel0 ? ch0   : ch6;
    assign sample_count = sel0 ? cnt0  : cnt6;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample s holds k=min(s+1,nv): tail samples repeat the last held input.
    function automatic logic [DW-1:0] exp_word(input int s, input int ch, input int nv);
        int k;
        k = (s + 1 < nv) ? s + 1 : nv;
        return (ch == 0) ? DW'(k) : DW'(-k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_capture(input int nv, output bit saw);
        abort = 1'b1; tick(); abort = 1'b0;
        arm   = 1'b1; tick(); arm   = 1'b0;
        saw = 1'b0;
        for (int k = 1; k <= nv; k++) begin
            in_valid = 1'b1;
            in_data  = {DW'(-k), DW'(k)};
            tick();
            if (out_valid) saw = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_scn(input scn_t s, input string tag);
        int words, w, cyc;
        bit saw, held;
        logic [DW-1:0] hd;
        logic hc, hl;
        sel0 = s.sel0;
        out_ready = 1'b0;
        start_capture(s.nv, saw);
        check($sformatf("%s early_read", tag), saw, s.exp_early);
        cyc = 0;
        while (!out_valid && cyc < 100) begin tick(); cyc++; end
        check($sformatf("%s first_valid", tag), out_valid, 1);
        check($sformatf("%s count", tag), sample_count, s.exp_cnt);
        check($sformatf("%s overflow", tag), overflow, s.exp_ovf);
        words = s.exp_cnt * NCH;
        w = 0; cyc = 0; held = 1'b0; hd = '0; hc = 1'b0; hl = 1'b0;
        while (w < words && cyc < 2000) begin
            if (held) begin
                check($sformatf("%s stall_valid[%0d]", tag, w), out_valid, 1);
                check($sformatf("%s stall_data[%0d]", tag, w), out_data, hd);
                check($sformatf("%s stall_ch[%0d]", tag, w), out_ch, hc);
                check($sformatf("%s stall_last[%0d]", tag, w), out_last, hl);
            end
            out_ready = s.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (out_valid && out_ready) begin
                check($sformatf("%s data[%0d]", tag, w), out_data, exp_word(w / NCH, w % NCH, s.nv));
                check($sformatf("%s ch[%0d]", tag, w), out_ch, w % NCH);
                check($sformatf("%s last[%0d]", tag, w), out_last, (w == words - 1));
                w++;
            end else if (out_valid) begin
                held = 1'b1; hd = out_data; hc = out_ch; hl = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check($sformatf("%s words", tag), w, words);
        check($sformatf("%s done", tag), done, 1);
        check($sformatf("%s valid_after", tag), out_valid, 0);
        check($sformatf("%s busy_after", tag), busy, 0);
        check($sformatf("%s count_after", tag), sample_count, s.exp_cnt);
        check($sformatf("%s overflow_after", tag), overflow, s.exp_ovf);
        tick();
        check($sformatf("%s done_pulse", tag), done, 0);
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s busy", tag), busy, 0);
        check($sformatf("%s out_valid", tag), out_valid, 0);
        check($sformatf("%s out_last", tag), out_last, 0);
        check($sformatf("%s out_data", tag), out_data, 0);
        check($sformatf("%s out_ch", tag), out_ch, 0);
        check($sformatf("%s done", tag), done, 0);
        check($sformatf("%s overflow", tag), overflow, 0);
        check($sformatf("%s count", tag), sample_count, 0);
    endtask

    initial begin
        scn_t scn [7];
        bit saw;
        int w, cyc;

        scn[0] = '{1'b0, 10, 1'b0, 16, 1'b0, 1'b0};
        scn[1] = '{1'b0, 40, 1'b0, 16, 1'b1, 1'b1};
        scn[2] = '{1'b0, 10, 1'b1, 16, 1'b0, 1'b0};
        scn[3] = '{1'b1,  5, 1'b0,  5, 1'b0, 1'b0};
        scn[4] = '{1'b0, 12, 1'b1, 16, 1'b1, 1'b0};
        scn[5] = '{1'b0,  3, 1'b1,  9, 1'b0, 1'b0};
        scn[6] = '{1'b1,  7, 1'b1,  7, 1'b0, 1'b0};

        void'($urandom(1));
        rstn = 1'b1; arm = 1'b0; abort = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; sel0 = 1'b0; in_data = '0;
        #2 rstn = 1'b0;
        #2 check_zero("reset");
        @(posedge clk); @(posedge clk);
        #3 rstn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_scn(scn[i], $sformatf("scn%0d", i));

        // Abort in READ after three words
        sel0 = 1'b0;
        start_capture(10, saw);
        cyc = 0;
        while (!out_valid && cyc < 100) begin tick(); cyc++; end
        out_ready = 1'b1;
        w = 0; cyc = 0;
        while (w < 3 && cyc < 100) begin
            if (out_valid) begin
                check($sformatf("abort data[%0d]", w), out_data, exp_word(w / NCH, w % NCH, 10));
                w++;
            end
            tick();
            cyc++;
        end
        check("abort words", w, 3);
        out_ready = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort count_kept", sample_count, 16);
        tick();
        check("abort done_late", done, 0);
        check("abort valid_late", out_valid, 0);
        run_scn('{1'b0, 8, 1'b1, 14, 1'b0, 1'b0}, "rearm");

        // Asynchronous reset in the middle of the tail
        sel0 = 1'b0;
        start_capture(4, saw);
        tick(); tick();
        check("pre_reset busy", busy, 1);
        #3 rstn = 1'b0;
        #1 check_zero("midreset");
        arm = 1'b1;
        tick();
        check("reset arm_ignored", busy, 0);
        #2 rstn = 1'b1;
        arm = 1'b0;
        tick();
        check("post_reset idle", busy, 0);
        run_scn('{1'b0, 6, 1'b0, 12, 1'b0, 1'b0}, "postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
